// File: rtl/test_card_gradient_checker.sv
// Gradient test-card sink checker: rebuilds the expected colour from active x/y and flags pixel and geometry faults.
// o_pix_err trails its pixel by 1 cycle, frame report 1 cycle after i_frame; no backpressure, stream never stalled.
module test_card_gradient_checker #(
  parameter int         H_RES      = 640,
  parameter int         V_RES      = 480,
  parameter int         X_SHIFT    = 4,
  parameter int         Y_SHIFT    = 1,
  parameter logic [7:0] BASE_RED   = 8'h00,
  parameter logic [7:0] BASE_GREEN = 8'h10,
  parameter logic [7:0] BASE_BLUE  = 8'h4C
) (
  input  logic        i_pix_clk,
  input  logic        i_rst,
  input  logic        i_frame,
  input  logic        i_de,
  input  logic [7:0]  i_red,
  input  logic [7:0]  i_green,
  input  logic [7:0]  i_blue,
  output logic        o_pix_err,
  output logic        o_geom_err,
  output logic        o_frame_done,
  output logic        o_frame_ok,
  output logic [15:0] o_err_count,
  output logic        o_locked
);

  localparam int XW = $clog2(H_RES + 1);
  localparam int YW = $clog2(V_RES + 1);
  localparam logic [XW-1:0] H_MAX = XW'(H_RES);
  localparam logic [YW-1:0] V_MAX = YW'(V_RES);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_CHECK = 1'b1;

  logic [0:0]    state_q, state_d;
  logic          locked_q, locked_d;
  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic          de_q, de_d;
  logic          geom_q, geom_d;
  logic [15:0]   cnt_q, cnt_d;
  logic          pix_err_q, pix_err_d;
  logic          done_q, done_d;
  logic          ok_q, ok_d;
  logic [15:0]   err_cnt_q, err_cnt_d;

  logic          active;
  logic          close;
  logic          line_end;
  logic [YW-1:0] y_line;
  logic          geom_line;
  logic [XW-1:0] bx;
  logic [YW-1:0] by;
  logic          bgeom;
  logic [15:0]   bcnt;
  logic [7:0]    xg;
  logic [7:0]    yg;
  logic [7:0]    exp_red;
  logic [7:0]    exp_green;
  logic [7:0]    exp_blue;
  logic          in_range;
  logic          mismatch;

  always_comb begin
    active   = i_frame || (state_q == ST_CHECK);
    close    = i_frame && (state_q == ST_CHECK);
    line_end = de_q && !i_de;

    // Counters as they stand once a line ending this cycle is accounted for;
    // the frame report uses them too, so a line closing on i_frame still counts.
    y_line    = (line_end && (y_q != V_MAX)) ? y_q + 1'b1 : y_q;
    geom_line = geom_q || (line_end && (x_q != H_MAX));

    // A pixel coincident with i_frame belongs to the new frame at (0,0).
    if (i_frame) begin
      bx    = '0;
      by    = '0;
      bgeom = 1'b0;
      bcnt  = '0;
    end else begin
      bx    = line_end ? '0 : x_q;
      by    = y_line;
      bgeom = geom_line;
      bcnt  = cnt_q;
    end

    xg        = 8'(bx >> X_SHIFT) & 8'h3F;
    yg        = 8'(by >> Y_SHIFT);
    exp_red   = BASE_RED + yg + xg;
    exp_green = BASE_GREEN + yg;
    exp_blue  = BASE_BLUE + yg;

    in_range = (bx != H_MAX) && (by != V_MAX);
    mismatch = (i_red != exp_red) || (i_green != exp_green) || (i_blue != exp_blue);

    state_d   = state_q;
    locked_d  = locked_q;
    x_d       = x_q;
    y_d       = y_q;
    de_d      = 1'b0;
    geom_d    = geom_q;
    cnt_d     = cnt_q;
    pix_err_d = 1'b0;
    done_d    = 1'b0;
    ok_d      = ok_q;
    err_cnt_d = err_cnt_q;

    if (i_frame) begin
      state_d  = ST_CHECK;
      locked_d = 1'b1;
    end

    if (active) begin
      de_d      = i_de;
      x_d       = (i_de && (bx != H_MAX)) ? bx + 1'b1 : bx;
      y_d       = by;
      geom_d    = bgeom || (i_de && !in_range);
      pix_err_d = i_de && in_range && mismatch;
      cnt_d     = (pix_err_d && (bcnt != 16'hFFFF)) ? bcnt + 16'd1 : bcnt;
    end

    // cnt_q already holds the error of the pixel just before i_frame.
    if (close) begin
      done_d    = 1'b1;
      err_cnt_d = cnt_q;
      ok_d      = (cnt_q == 16'd0) && !geom_line && (y_line == V_MAX) && !i_de;
    end
  end

  always_ff @(posedge i_pix_clk) begin
    if (i_rst) begin
      state_q   <= ST_IDLE;
      locked_q  <= 1'b0;
      x_q       <= '0;
      y_q       <= '0;
      de_q      <= 1'b0;
      geom_q    <= 1'b0;
      cnt_q     <= '0;
      pix_err_q <= 1'b0;
      done_q    <= 1'b0;
      ok_q      <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      locked_q  <= locked_d;
      x_q       <= x_d;
      y_q       <= y_d;
      de_q      <= de_d;
      geom_q    <= geom_d;
      cnt_q     <= cnt_d;
      pix_err_q <= pix_err_d;
      done_q    <= done_d;
      ok_q      <= ok_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign o_pix_err    = pix_err_q;
  assign o_geom_err   = geom_q;
  assign o_frame_done = done_q;
  assign o_frame_ok   = ok_q;
  assign o_err_count  = err_cnt_q;
  assign o_locked     = locked_q;

endmodule

// File: tb/tb_test_card_gradient_checker.sv
// Bench for the gradient checker: a small-geometry instance for frame-level behaviour and a
// full 640x480 instance for gradient wrap values and error-count saturation, sharing one input stream.
module tb_test_card_gradient_checker;

  localparam int A_H = 48;
  localparam int A_V = 16;
  localparam int NV  = 11;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_frame;
  logic        i_de;
  logic [7:0]  i_red;
  logic [7:0]  i_green;
  logic [7:0]  i_blue;

  logic        o_pix_err_a, o_geom_err_a, o_frame_done_a, o_frame_ok_a, o_locked_a;
  logic [15:0] o_err_count_a;
  logic        o_pix_err_b, o_geom_err_b, o_frame_done_b, o_frame_ok_b, o_locked_b;
  logic [15:0] o_err_count_b;

  int n_cmp = 0;
  int n_bad = 0;
  int pe_a  = 0;
  int fd_a  = 0;

  typedef struct {
    int         x;
    int         y;
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
    logic       e;
  } vec_t;

  vec_t vecs[NV];

  always #5 clk = ~clk;

  test_card_gradient_checker #(
    .H_RES(A_H), .V_RES(A_V), .X_SHIFT(4), .Y_SHIFT(1),
    .BASE_RED(8'h00), .BASE_GREEN(8'h10), .BASE_BLUE(8'h4C)
  ) u_dut_a (
    .i_pix_clk(clk), .i_rst(rst), .i_frame(i_frame), .i_de(i_de),
    .i_red(i_red), .i_green(i_green), .i_blue(i_blue),
    .o_pix_err(o_pix_err_a), .o_geom_err(o_geom_err_a), .o_frame_done(o_frame_done_a),
    .o_frame_ok(o_frame_ok_a), .o_err_count(o_err_count_a), .o_locked(o_locked_a)
  );

  test_card_gradient_checker u_dut_b (
    .i_pix_clk(clk), .i_rst(rst), .i_frame(i_frame), .i_de(i_de),
    .i_red(i_red), .i_green(i_green), .i_blue(i_blue),
    .o_pix_err(o_pix_err_b), .o_geom_err(o_geom_err_b), .o_frame_done(o_frame_done_b),
    .o_frame_ok(o_frame_ok_b), .o_err_count(o_err_count_b), .o_locked(o_locked_b)
  );

  always @(negedge clk) begin
    if (o_pix_err_a)    pe_a <= pe_a + 1;
    if (o_frame_done_a) fd_a <= fd_a + 1;
  end

  function automatic logic [23:0] grad(input int x, input int y);
    logic [7:0] xg;
    logic [7:0] yg;
    xg = 8'((x >> 4) & 63);
    yg = 8'((y >> 1) & 255);
    return {8'h00 + yg + xg, 8'h10 + yg, 8'h4C + yg};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic put(input logic fr, input logic de, input logic [23:0] px);
    i_frame = fr;
    i_de    = de;
    {i_red, i_green, i_blue} = px;
    @(posedge clk);
    #1;
  endtask

  // Lines of A_H pixels plus 2 blanking cycles; bad indices (y*A_H+x) corrupt red, blue, green.
  task automatic run_frame(input int nlines, input int x0, input int long_y,
                           input int bad0, input int bad1, input int bad2);
    logic [23:0] px;
    int          len;
    int          k;
    logic        bad;
    logic        chk_low;
    chk_low = 1'b0;
    for (int y = 0; y < nlines; y++) begin
      len = (y == long_y) ? A_H + 1 : A_H;
      for (int x = (y == 0) ? x0 : 0; x < len; x++) begin
        px  = grad(x, y);
        k   = y * A_H + x;
        bad = (x < A_H) && (k == bad0 || k == bad1 || k == bad2);
        if (x < A_H && k == bad0) px = px ^ 24'h010000;
        if (x < A_H && k == bad1) px = px ^ 24'h000040;
        if (x < A_H && k == bad2) px = px ^ 24'h008000;
        put(1'b0, 1'b1, px);
        if (chk_low) chk("pix_err_width", {31'd0, o_pix_err_a}, 0);
        chk_low = bad;
        if (bad) chk("pix_err_latency", {31'd0, o_pix_err_a}, 1);
        if (x == A_H) chk("geom_long_line", {31'd0, o_geom_err_a}, 1);
      end
      put(1'b0, 1'b0, 24'd0);
      if (chk_low) chk("pix_err_width", {31'd0, o_pix_err_a}, 0);
      chk_low = 1'b0;
      put(1'b0, 1'b0, 24'd0);
    end
  endtask

  task automatic close_chk(input string nm, input logic exp_ok, input logic [15:0] exp_cnt);
    put(1'b1, 1'b0, 24'd0);
    chk({nm, "_done"}, {31'd0, o_frame_done_a}, 1);
    chk({nm, "_ok"}, {31'd0, o_frame_ok_a}, {31'd0, exp_ok});
    chk({nm, "_cnt"}, {16'd0, o_err_count_a}, {16'd0, exp_cnt});
    chk({nm, "_geom_clr"}, {31'd0, o_geom_err_a}, 0);
    put(1'b0, 1'b0, 24'd0);
    chk({nm, "_done_pulse"}, {31'd0, o_frame_done_a}, 0);
    chk({nm, "_ok_hold"}, {31'd0, o_frame_ok_a}, {31'd0, exp_ok});
  endtask

  initial begin
    int pe0;
    int fd0;

    vecs[0]  = '{0,   0,   8'h00, 8'h10, 8'h4C, 1'b0};
    vecs[1]  = '{17,  3,   8'h02, 8'h11, 8'h4D, 1'b0};
    vecs[2]  = '{32,  10,  8'h07, 8'h15, 8'h51, 1'b0};
    vecs[3]  = '{32,  10,  8'h07, 8'h16, 8'h51, 1'b1};
    vecs[4]  = '{100, 200, 8'h6A, 8'h74, 8'hB0, 1'b0};
    vecs[5]  = '{100, 200, 8'h6A, 8'h74, 8'hB1, 1'b1};
    vecs[6]  = '{320, 240, 8'h8C, 8'h88, 8'hC4, 1'b0};
    vecs[7]  = '{639, 0,   8'h27, 8'h10, 8'h4C, 1'b0};
    vecs[8]  = '{0,   479, 8'hEF, 8'hFF, 8'h3B, 1'b0};
    vecs[9]  = '{639, 479, 8'h16, 8'hFF, 8'h3B, 1'b0};
    vecs[10] = '{639, 479, 8'h16, 8'h7F, 8'h3B, 1'b1};

    rst = 1'b1;
    put(1'b0, 1'b0, 24'd0);
    put(1'b0, 1'b0, 24'd0);
    chk("rst_pix_err", {31'd0, o_pix_err_a}, 0);
    chk("rst_geom", {31'd0, o_geom_err_a}, 0);
    chk("rst_done", {31'd0, o_frame_done_a}, 0);
    chk("rst_ok", {31'd0, o_frame_ok_a}, 0);
    chk("rst_cnt", {16'd0, o_err_count_a}, 0);
    chk("rst_locked", {31'd0, o_locked_a}, 0);
    rst = 1'b0;

    // Wrong pixels before any i_frame are ignored.
    pe0 = pe_a;
    for (int x = 0; x < A_H; x++) put(1'b0, 1'b1, 24'hFFFFFF);
    put(1'b0, 1'b0, 24'd0);
    put(1'b0, 1'b0, 24'd0);
    chk("prelock_pix_err", pe_a - pe0, 0);
    chk("prelock_geom", {31'd0, o_geom_err_a}, 0);
    chk("prelock_locked", {31'd0, o_locked_a}, 0);

    put(1'b1, 1'b0, 24'd0);
    chk("lock_locked", {31'd0, o_locked_a}, 1);
    chk("lock_no_done", {31'd0, o_frame_done_a}, 0);

    pe0 = pe_a;
    run_frame(A_V, 0, -1, -1, -1, -1);
    chk("clean_no_pix_err", pe_a - pe0, 0);
    close_chk("clean", 1'b1, 16'd0);

    pe0 = pe_a;
    run_frame(A_V, 0, -1, 0, 10 * A_H + 32, 15 * A_H + 47);
    chk("three_pulses", pe_a - pe0, 3);
    close_chk("three_bad", 1'b0, 16'd3);

    run_frame(A_V, 0, 5, -1, -1, -1);
    chk("cnt_hold", {16'd0, o_err_count_a}, 3);
    close_chk("long_line", 1'b0, 16'd0);

    run_frame(A_V - 1, 0, -1, -1, -1, -1);
    chk("short_geom", {31'd0, o_geom_err_a}, 0);
    close_chk("short_frame", 1'b0, 16'd0);

    run_frame(A_V, 0, -1, -1, -1, -1);
    close_chk("recover", 1'b1, 16'd0);

    // i_frame with i_de: old frame fails, bad pixel counts as (0,0) of the new one.
    run_frame(A_V, 0, -1, -1, -1, -1);
    put(1'b1, 1'b1, grad(0, 0) ^ 24'h010000);
    chk("coinc_done", {31'd0, o_frame_done_a}, 1);
    chk("coinc_ok", {31'd0, o_frame_ok_a}, 0);
    chk("coinc_cnt", {16'd0, o_err_count_a}, 0);
    chk("coinc_pix_err", {31'd0, o_pix_err_a}, 1);
    run_frame(A_V, 1, -1, -1, -1, -1);
    close_chk("coinc_next", 1'b0, 16'd1);

    // Last pixel wrong with i_frame straight after it: pending error is in the report.
    run_frame(A_V - 1, 0, -1, -1, -1, -1);
    for (int x = 0; x < A_H - 1; x++) put(1'b0, 1'b1, grad(x, A_V - 1));
    put(1'b0, 1'b1, grad(A_H - 1, A_V - 1) ^ 24'h008000);
    chk("pending_pix_err", {31'd0, o_pix_err_a}, 1);
    put(1'b1, 1'b0, 24'd0);
    chk("pending_done", {31'd0, o_frame_done_a}, 1);
    chk("pending_cnt", {16'd0, o_err_count_a}, 1);
    chk("pending_ok", {31'd0, o_frame_ok_a}, 0);
    put(1'b0, 1'b0, 24'd0);

    // Reset mid-frame right after a bad pixel.
    run_frame(2, 0, -1, -1, -1, -1);
    put(1'b0, 1'b1, grad(0, 2) ^ 24'h010000);
    chk("midrst_pre_pix_err", {31'd0, o_pix_err_a}, 1);
    fd0 = fd_a;
    rst = 1'b1;
    put(1'b0, 1'b0, 24'd0);
    rst = 1'b0;
    chk("midrst_pix_err", {31'd0, o_pix_err_a}, 0);
    chk("midrst_geom", {31'd0, o_geom_err_a}, 0);
    chk("midrst_done", {31'd0, o_frame_done_a}, 0);
    chk("midrst_ok", {31'd0, o_frame_ok_a}, 0);
    chk("midrst_cnt", {16'd0, o_err_count_a}, 0);
    chk("midrst_locked", {31'd0, o_locked_a}, 0);
    pe0 = pe_a;
    for (int y = 0; y < 3; y++) begin
      for (int x = 0; x < A_H; x++) put(1'b0, 1'b1, grad(x, y) ^ 24'hFF0000);
      put(1'b0, 1'b0, 24'd0);
      put(1'b0, 1'b0, 24'd0);
    end
    chk("midrst_ignored_pix", pe_a - pe0, 0);
    chk("midrst_no_report", fd_a - fd0, 0);
    chk("midrst_still_unlocked", {31'd0, o_locked_a}, 0);
    put(1'b1, 1'b0, 24'd0);
    chk("relock_locked", {31'd0, o_locked_a}, 1);
    chk("relock_no_done", {31'd0, o_frame_done_a}, 0);
    run_frame(A_V, 0, -1, -1, -1, -1);
    close_chk("relock_clean", 1'b1, 16'd0);

    // Full-size instance: hand-computed gradient samples, reached via 1-pixel lines.
    for (int i = 0; i < NV; i++) begin
      put(1'b1, 1'b0, 24'd0);
      for (int yy = 0; yy < vecs[i].y; yy++) begin
        put(1'b0, 1'b1, grad(0, yy));
        put(1'b0, 1'b0, 24'd0);
      end
      for (int xx = 0; xx < vecs[i].x; xx++) put(1'b0, 1'b1, grad(xx, vecs[i].y));
      put(1'b0, 1'b1, {vecs[i].r, vecs[i].g, vecs[i].b});
      chk($sformatf("vec%0d_pix_err", i), {31'd0, o_pix_err_b}, {31'd0, vecs[i].e});
      put(1'b0, 1'b0, 24'd0);
      chk($sformatf("vec%0d_pix_err_width", i), {31'd0, o_pix_err_b}, 0);
    end

    // 103 lines of 640 wrong pixels = 65920 errors, beyond the 16-bit range.
    put(1'b1, 1'b0, 24'd0);
    for (int y = 0; y < 103; y++) begin
      for (int x = 0; x < 640; x++) put(1'b0, 1'b1, grad(x, y) ^ 24'hFF0000);
      put(1'b0, 1'b0, 24'd0);
    end
    put(1'b1, 1'b0, 24'd0);
    chk("sat_done", {31'd0, o_frame_done_b}, 1);
    chk("sat_cnt", {16'd0, o_err_count_b}, 32'h0000FFFF);
    chk("sat_ok", {31'd0, o_frame_ok_b}, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
